// File: rtl/sum_splitter_pkg.sv
// Shared types and helpers for splitter/throttle blocks that break a total
// into bounded per-cycle increments.
package sum_splitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STEP_W = 32;

    // Clipped increment: never more than what is left, never more than the cap.
    function automatic logic [STEP_W-1:0] min_step(
        input logic [STEP_W-1:0] remaining,
        input logic [STEP_W-1:0] max_step
    );
        return (remaining < max_step) ? remaining : max_step;
    endfunction

endpackage

// File: rtl/sum_splitter.sv
// Splits a loaded total into a valid/ready stream of increments of at most
// MAX_STEP each; the accepted beats sum exactly to the loaded total.
module sum_splitter
    import sum_splitter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_STEP = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_total,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [WIDTH-1:0] beat_count
);

    generate
        if (WIDTH < 1 || WIDTH > STEP_W) begin : g_bad_width
            $error("sum_splitter: WIDTH must be 1..32");
        end
        if (MAX_STEP < 1 || longint'(MAX_STEP) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_step
            $error("sum_splitter: MAX_STEP must be in 1..2**WIDTH-1");
        end
    endgenerate

    localparam logic [WIDTH-1:0] STEP = WIDTH'(MAX_STEP);

    state_t           state, state_nx;
    logic [WIDTH-1:0] remaining, remaining_nx;
    logic [WIDTH-1:0] beat_nx;
    logic [WIDTH-1:0] step;

    assign step = WIDTH'(min_step(STEP_W'(remaining), STEP_W'(MAX_STEP)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            beat_count <= '0;
        end else begin
            state      <= state_nx;
            remaining  <= remaining_nx;
            beat_count <= beat_nx;
        end
    end

    // Outputs decode only registered state; out_ready/load_valid steer next state.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        beat_nx      = beat_count;
        load_ready   = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nx     = RUN;
                    remaining_nx = load_total;
                    beat_nx      = '0;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = step;
                out_last  = (remaining <= STEP);
                if (out_ready) begin
                    remaining_nx = remaining - step;
                    beat_nx      = beat_count + 1'b1;
                    if (out_last) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sum_splitter.sv
// Directed bench: stimulus pushes hand-computed beats into a scoreboard queue,
// an independent monitor pops and compares on every accepted beat.
module tb_sum_splitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_total = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [7:0] beat_count;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    acc = 0;
    int    last_sum = -1;
    logic       stalled = 1'b0;
    logic [7:0] held_d;
    logic       held_l;

    sum_splitter #(.WIDTH(8), .MAX_STEP(16)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_ready(load_ready), .load_total(load_total),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input bit l);
        beat_t b;
        b.d = 8'(d);
        b.l = l;
        sb.push_back(b);
    endtask

    // Monitor: samples on the falling edge, between input updates and the active edge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (stalled) begin
                chk("stall_data_stable", int'(out_data), int'(held_d));
                chk("stall_last_stable", int'(out_last), int'(held_l));
            end
            if (out_ready) begin
                stalled = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", int'(out_data), -1);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_data", int'(out_data), int'(e.d));
                    chk("beat_last", int'(out_last), int'(e.l));
                end
                acc += int'(out_data);
                if (out_last) begin
                    last_sum = acc;
                    acc = 0;
                end
            end else begin
                stalled = 1'b1;
                held_d  = out_data;
                held_l  = out_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic do_load(input int t);
        load_valid = 1'b1;
        load_total = 8'(t);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (load_ready && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({name, "_idle_reached"}, int'(done), 1);
        if (!done) sb.delete();
    endtask

    initial begin
        #2;
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_beat_count", int'(beat_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 40 -> 16,16,8 with back-to-back acceptance
        push(16, 0); push(16, 0); push(8, 1);
        do_load(40);
        chk("t40_first_valid", int'(out_valid), 1);
        chk("t40_busy", int'(busy), 1);
        chk("t40_load_ready_low", int'(load_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t40_not_ready_before_last", int'(load_ready), 0);
        @(posedge clk);
        #1;
        chk("t40_load_ready_after_last", int'(load_ready), 1);
        chk("t40_beat_count", int'(beat_count), 3);
        chk("t40_sum", last_sum, 40);
        wait_idle("t40");

        // zero total
        push(0, 1);
        do_load(0);
        wait_idle("t0");
        chk("t0_beat_count", int'(beat_count), 1);
        @(posedge clk);
        #1;
        chk("t0_count_held", int'(beat_count), 1);

        // exactly one step
        push(16, 1);
        do_load(16);
        wait_idle("t16");
        chk("t16_beat_count", int'(beat_count), 1);

        // one step plus one
        push(16, 0); push(1, 1);
        do_load(17);
        wait_idle("t17");
        chk("t17_beat_count", int'(beat_count), 2);
        chk("t17_sum", last_sum, 17);

        // load_valid held with changing totals during RUN must be ignored
        push(16, 0); push(16, 0); push(1, 1);
        do_load(33);
        load_valid = 1'b1;
        load_total = 8'd99;
        @(posedge clk); #1;
        load_total = 8'd3;
        @(posedge clk); #1;
        load_total = 8'd200;
        @(posedge clk); #1;
        load_valid = 1'b0;
        wait_idle("t33");
        chk("t33_beat_count", int'(beat_count), 3);
        chk("t33_sum", last_sum, 33);
        chk("t33_no_reload", int'(busy), 0);

        // 255 under random backpressure
        for (int i = 0; i < 15; i++) push(16, 0);
        push(15, 1);
        do_load(255);
        for (int c = 0; c < 400; c++) begin
            if (load_ready) break;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_idle("t255");
        chk("t255_beat_count", int'(beat_count), 16);
        chk("t255_acc", last_sum, 255);

        // async reset after two of three beats
        push(16, 0); push(16, 0); push(8, 1);
        do_load(40);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_load_ready", int'(load_ready), 1);
        chk("mid_rst_beat_count", int'(beat_count), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        sb.delete();
        acc = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(5, 1);
        do_load(5);
        wait_idle("t5");
        chk("t5_beat_count", int'(beat_count), 1);
        chk("t5_sum", last_sum, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
